branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 159 +++++++++++++++
 tb/tb_branch_resolve_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// Branch resolution queue: resolves up to NrChannels branches per cycle, checks target
// alignment and PCC bounds, and presents results in program order at the head.
module branch_resolve_queue #(
   parameter int unsigned VLEN         = 39,
   parameter int unsigned NrChannels   = 2,
   parameter int unsigned Depth        = 4,
   parameter int unsigned RVC          = 1,
   parameter int unsigned CheriPresent = 0
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic [NrChannels-1:0]               in_valid_i,
   output logic                                in_ready_o,
   input  logic [NrChannels-1:0][VLEN-1:0]     in_pc_i,
   input  logic [NrChannels-1:0][VLEN-1:0]     in_target_i,
   input  logic [NrChannels-1:0]               in_compressed_i,
   input  logic [NrChannels-1:0]               in_taken_i,
   input  logic [NrChannels-1:0]               in_pred_taken_i,
   input  logic [NrChannels-1:0][VLEN-1:0]     in_pred_target_i,
   input  logic [NrChannels-1:0][VLEN-1:0]     in_base_i,
   input  logic [NrChannels-1:0][VLEN:0]       in_top_i,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [VLEN-1:0]                     out_pc_o,
   output logic [VLEN-1:0]                     out_target_o,
   output logic                                out_mispredict_o,
   output logic [1:0]                          out_exc_o,
   output logic [$clog2(Depth):0]              count_o
);

   localparam int unsigned AW = $clog2(Depth);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   typedef logic [VLEN-1:0] vaddr_t;
   typedef logic [VLEN:0]   ext_t;

   localparam cnt_t MAX_FILL = cnt_t'(Depth - NrChannels);

   logic [NrChannels-1:0][VLEN-1:0] res_target_s;
   logic [NrChannels-1:0]           res_mis_s;
   logic [NrChannels-1:0][1:0]      res_exc_s;
   ptr_t                            slot_s [NrChannels];
   cnt_t                            valid_cnt_s;
   cnt_t                            npush_s;
   logic                            accept_s;
   logic                            pop_s;
   logic                            squash_s;

   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t wr_ptr_q, wr_ptr_d;
   cnt_t count_q,  count_d;

   vaddr_t     pc_mem_q  [Depth];
   vaddr_t     tgt_mem_q [Depth];
   logic       mis_mem_q [Depth];
   logic [1:0] exc_mem_q [Depth];

   // Per-channel resolution: next PC, mispredict and exception class
   always_comb begin
      res_target_s = '0;
      res_mis_s    = '0;
      res_exc_s    = '0;
      for (int c = 0; c < NrChannels; c++) begin
         logic misal_v;
         logic lenv_v;
         ext_t tgt_ext_v;
         tgt_ext_v = {1'b0, in_target_i[c]};
         misal_v = in_taken_i[c] &
                   (in_target_i[c][0] | ((RVC == 32'd0) & in_target_i[c][1]));
         lenv_v  = (CheriPresent != 32'd0) & in_taken_i[c] &
                   ((tgt_ext_v < {1'b0, in_base_i[c]}) |
                    ((tgt_ext_v + ext_t'(2)) > in_top_i[c]));
         if (in_taken_i[c]) begin
            res_target_s[c] = in_target_i[c];
         end else begin
            res_target_s[c] = in_pc_i[c] + (in_compressed_i[c] ? vaddr_t'(2) : vaddr_t'(4));
         end
         res_mis_s[c] = (in_taken_i[c] != in_pred_taken_i[c]) |
                        (in_taken_i[c] & (in_target_i[c] != in_pred_target_i[c]));
         if (lenv_v) begin
            res_exc_s[c] = 2'd2;
         end else if (misal_v) begin
            res_exc_s[c] = 2'd1;
         end else begin
            res_exc_s[c] = 2'd0;
         end
      end
   end

   assign in_ready_o  = (count_q <= MAX_FILL);
   assign out_valid_o = (count_q != cnt_t'(0));
   assign accept_s    = in_ready_o & ~flush_i;
   assign pop_s       = out_valid_o & out_ready_i;
   assign squash_s    = pop_s & (mis_mem_q[rd_ptr_q] | (exc_mem_q[rd_ptr_q] != 2'd0));

   // Compacting slot assignment: only valid channels take consecutive slots
   always_comb begin
      valid_cnt_s = '0;
      for (int c = 0; c < NrChannels; c++) begin
         slot_s[c]   = wr_ptr_q + ptr_t'(valid_cnt_s);
         valid_cnt_s = valid_cnt_s + cnt_t'(in_valid_i[c]);
      end
      if (accept_s) begin
         npush_s = valid_cnt_s;
      end else begin
         npush_s = '0;
      end
   end

   // Pointer and occupancy next state; flush and squash empty the queue
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i | squash_s) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + ptr_t'(pop_s);
         wr_ptr_d = wr_ptr_q + ptr_t'(npush_s);
         count_d  = count_q + npush_s - cnt_t'(pop_s);
      end
   end

   // Control state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; writes on squash are harmless since pointers are cleared
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NrChannels; c++) begin
         if (accept_s & in_valid_i[c]) begin
            pc_mem_q[slot_s[c]]  <= in_pc_i[c];
            tgt_mem_q[slot_s[c]] <= res_target_s[c];
            mis_mem_q[slot_s[c]] <= res_mis_s[c];
            exc_mem_q[slot_s[c]] <= res_exc_s[c];
         end
      end
   end

   assign out_pc_o         = pc_mem_q[rd_ptr_q];
   assign out_target_o     = tgt_mem_q[rd_ptr_q];
   assign out_mispredict_o = mis_mem_q[rd_ptr_q];
   assign out_exc_o        = exc_mem_q[rd_ptr_q];
   assign count_o          = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized scoreboard bench for branch_resolve_queue with a queue-based reference model.
module tb_branch_resolve_queue;

   localparam int VLEN = 39;
   localparam int NCH  = 2;
   localparam int DEP  = 4;

   typedef struct {
      logic [VLEN-1:0] pc;
      logic [VLEN-1:0] tgt;
      logic            mis;
      logic [1:0]      exc;
   } exp_t;

   logic                      clk = 1'b0;
   logic                      rst, flush, out_ready;
   logic [NCH-1:0]            valid, comp, taken, pt;
   logic [NCH-1:0][VLEN-1:0]  pc, tgt, ptgt, base;
   logic [NCH-1:0][VLEN:0]    top;
   logic                      in_ready, out_valid, out_mis;
   logic [VLEN-1:0]           out_pc, out_tgt;
   logic [1:0]                out_exc;
   logic [$clog2(DEP):0]      count;

   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   exp_t model_q[$];

   branch_resolve_queue #(.VLEN(VLEN), .NrChannels(NCH), .Depth(DEP), .RVC(1), .CheriPresent(1)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(valid), .in_ready_o(in_ready),
      .in_pc_i(pc), .in_target_i(tgt), .in_compressed_i(comp),
      .in_taken_i(taken), .in_pred_taken_i(pt), .in_pred_target_i(ptgt),
      .in_base_i(base), .in_top_i(top),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_pc_o(out_pc), .out_target_o(out_tgt),
      .out_mispredict_o(out_mis), .out_exc_o(out_exc), .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected result of one channel, straight from the branch rules
   function automatic exp_t predict(input int c);
      exp_t   e;
      longint t;
      bit     lenv, misal;
      t      = longint'(tgt[c]);
      e.pc   = pc[c];
      e.tgt  = taken[c] ? tgt[c] : VLEN'(longint'(pc[c]) + (comp[c] ? 2 : 4));
      e.mis  = taken[c] ? (!pt[c] || tgt[c] != ptgt[c]) : pt[c];
      lenv   = taken[c] && (t < longint'(base[c]) || t + 2 > longint'(top[c]));
      misal  = taken[c] && (t % 2 == 1);
      e.exc  = lenv ? 2'd2 : (misal ? 2'd1 : 2'd0);
      return e;
   endfunction

   // Reference model: advances on every active edge from the applied stimulus
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            model_q.delete();
            mon_en = 1'b1;
         end else if (flush) begin
            model_q.delete();
         end else begin
            int n;
            bit rdy, sq;
            n   = model_q.size();
            rdy = (DEP - n) >= NCH;
            sq  = 1'b0;
            if (n > 0 && out_ready) begin
               sq = model_q[0].mis || (model_q[0].exc != 2'd0);
               void'(model_q.pop_front());
            end
            if (sq) model_q.delete();
            else if (rdy) begin
               for (int c = 0; c < NCH; c++)
                  if (valid[c]) model_q.push_back(predict(c));
            end
         end
      end
   end

   // Monitor: compares DUT state and head entry against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("count", count, model_q.size());
            chk("in_ready", in_ready, (DEP - model_q.size()) >= NCH);
            chk("out_valid", out_valid, model_q.size() != 0);
            if (out_valid && model_q.size() != 0) begin
               chk("head_pc", out_pc, model_q[0].pc);
               chk("head_target", out_tgt, model_q[0].tgt);
               chk("head_mispredict", out_mis, model_q[0].mis);
               chk("head_exc", out_exc, model_q[0].exc);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [VLEN-1:0] p, input logic [VLEN-1:0] t,
                         input logic cm, input logic tk, input logic ptk, input logic [VLEN-1:0] pt_t);
      pc[c] = p; tgt[c] = t; comp[c] = cm; taken[c] = tk; pt[c] = ptk; ptgt[c] = pt_t;
      base[c] = '0; top[c] = {1'b1, {VLEN{1'b0}}};
   endtask

   initial begin
      logic [63:0] r;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; valid = '0;
      for (int c = 0; c < NCH; c++) set_ch(c, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      tick(); tick();
      rst = 1'b0;
      chk("reset_count", count, 0);
      chk("reset_ready", in_ready, 1);
      chk("reset_valid", out_valid, 0);

      // Sequential compressed branch
      set_ch(0, 39'h100, 39'h0, 1'b1, 1'b0, 1'b0, 39'h0); valid = 2'b01;
      tick(); valid = '0;
      chk("seq_valid", out_valid, 1);
      chk("seq_target", out_tgt, 39'h102);
      chk("seq_mis", out_mis, 0);
      chk("seq_exc", out_exc, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Misaligned taken target, correctly predicted
      set_ch(0, 39'h200, 39'h203, 1'b0, 1'b1, 1'b1, 39'h203); valid = 2'b01;
      tick(); valid = '0;
      chk("misal_exc", out_exc, 1);
      chk("misal_mis", out_mis, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Bounds: 0x100E fits, 0x100F overruns top
      set_ch(0, 39'h400, 39'h100E, 1'b0, 1'b1, 1'b1, 39'h100E);
      set_ch(1, 39'h404, 39'h100F, 1'b0, 1'b1, 1'b1, 39'h100F);
      for (int c = 0; c < NCH; c++) begin base[c] = 39'h1000; top[c] = 40'h1010; end
      valid = 2'b11; tick(); valid = '0;
      chk("bounds_ok_exc", out_exc, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("bounds_viol_exc", out_exc, 2);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Fill to Depth, then one pop keeps in_ready low
      set_ch(0, 39'h300, 39'h0, 1'b0, 1'b0, 1'b0, 39'h0);
      set_ch(1, 39'h304, 39'h0, 1'b0, 1'b0, 1'b0, 39'h0);
      valid = 2'b11; tick();
      pc[0] = 39'h308; pc[1] = 39'h30C; tick(); valid = '0;
      chk("full_count", count, 4);
      chk("full_ready", in_ready, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("pop1_count", count, 3);
      chk("pop1_ready", in_ready, 0);
      flush = 1'b1; tick(); flush = 1'b0;

      // Mispredicted head squashes younger entries and same-cycle pushes
      set_ch(0, 39'h500, 39'h600, 1'b0, 1'b1, 1'b0, 39'h0);
      set_ch(1, 39'h504, 39'h0, 1'b0, 1'b0, 1'b0, 39'h0);
      valid = 2'b11; tick();
      set_ch(0, 39'h508, 39'h0, 1'b0, 1'b0, 1'b0, 39'h0);
      valid = 2'b01; tick();
      chk("squash_pre_count", count, 3);
      valid = 2'b11; out_ready = 1'b1; tick(); valid = '0; out_ready = 1'b0;
      chk("squash_count", count, 0);

      // Pointer wrap: stream pairs while popping, then drain
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_ch(0, 39'h700 + 39'(i * 8), 39'h0, 1'b0, 1'b0, 1'b0, 39'h0);
         set_ch(1, 39'h704 + 39'(i * 8), 39'h0, 1'b1, 1'b0, 1'b0, 39'h0);
         valid = 2'b11; tick();
      end
      valid = '0;
      for (int i = 0; i < 8; i++) tick();
      out_ready = 1'b0;

      // Flush concurrent with a push
      valid = 2'b11; tick();
      flush = 1'b1; tick(); flush = 1'b0; valid = '0;
      chk("flush_count", count, 0);

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < NCH; c++) begin
            r = {$urandom(), $urandom()};
            pc[c]    = ($urandom_range(0, 7) == 0) ? ({VLEN{1'b1}} - VLEN'($urandom_range(0, 3))) : r[VLEN-1:0];
            r = {$urandom(), $urandom()};
            tgt[c]   = r[VLEN-1:0];
            if ($urandom_range(0, 7) != 0) tgt[c][0] = 1'b0;
            comp[c]  = 1'($urandom_range(0, 1));
            taken[c] = 1'($urandom_range(0, 1));
            pt[c]    = ($urandom_range(0, 5) == 0) ? ~taken[c] : taken[c];
            ptgt[c]  = ($urandom_range(0, 5) == 0) ? ~tgt[c] : tgt[c];
            base[c]  = ($urandom_range(0, 7) == 0) ? tgt[c] + 39'd1 : '0;
            top[c]   = ($urandom_range(0, 7) == 0) ? {1'b0, tgt[c]} + 40'd1 : {1'b1, {VLEN{1'b0}}};
         end
         valid     = NCH'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         rst       = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0; flush = 1'b0; valid = '0; out_ready = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
